// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - request and tagged-result bus bundle for mul_share_arbiter
interface mul_share_arbiter_if #(
  parameter int n = 8
);
  logic           req0_valid;
  logic           req0_ready;
  logic [n-1:0]   req0_a;
  logic [n-1:0]   req0_b;
  logic           req0_signed;

  logic           req1_valid;
  logic           req1_ready;
  logic [n-1:0]   req1_a;
  logic [n-1:0]   req1_b;
  logic           req1_signed;

  logic           out_valid;
  logic           out_ready;
  logic [2*n-1:0] out_res;
  logic           out_id;

  // Multiplier side: consumes operand pairs, produces tagged results.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_signed,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_signed,
    output req1_ready,
    output out_valid, out_res, out_id,
    input  out_ready
  );

  // Producer/consumer side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_signed,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_signed,
    input  req1_ready,
    input  out_valid, out_res, out_id,
    output out_ready
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - two-requester arbiter sharing one pipelined multiplier (option: MUL_SHARE_ARB_FIXED_PRIO_EN)
module mul_share_arbiter #(
  parameter int n      = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mul_share_arbiter_if.slave bus
);
  localparam int W = 2 * n;

  logic                       adv;
  logic                       grant;
  logic                       xfer;
  logic [n-1:0]               a_sel;
  logic [n-1:0]               b_sel;
  logic                       sgn_sel;
  logic [W-1:0]               a_ext;
  logic [W-1:0]               b_ext;
  logic [W-1:0]               prod;

  logic [STAGES-1:0]          vld;
  logic [STAGES-1:0]          id_q;
  logic [STAGES-1:0][W-1:0]   res_q;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign adv = !vld[STAGES-1] || bus.out_ready;

`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
  // Requester 0 always wins; requester 1 only gets idle slots.
  always_comb begin
    grant = 1'b0;
    if (!bus.req0_valid && bus.req1_valid) grant = 1'b1;
  end
`else
  logic last_grant;

  // Round-robin: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    grant = !last_grant;
    if (bus.req0_valid && !bus.req1_valid) grant = 1'b0;
    else if (bus.req1_valid && !bus.req0_valid) grant = 1'b1;
  end

  // Remember who was served by the most recent transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= 1'b1;
    else if (xfer) last_grant <= grant;
  end
`endif

  assign bus.req0_ready = adv && !grant;
  assign bus.req1_ready = adv && grant;
  assign xfer           = adv && (grant ? bus.req1_valid : bus.req0_valid);

  // Select the winner's operands and widen them; sign bits replicate only in signed mode,
  // so one 2n-bit multiply yields the correct product for both modes.
  always_comb begin
    a_sel   = grant ? bus.req1_a      : bus.req0_a;
    b_sel   = grant ? bus.req1_b      : bus.req0_b;
    sgn_sel = grant ? bus.req1_signed : bus.req0_signed;
    a_ext   = {{n{sgn_sel & a_sel[n-1]}}, a_sel};
    b_ext   = {{n{sgn_sel & b_sel[n-1]}}, b_sel};
    prod    = a_ext * b_ext;
  end

  // First stage captures the accepted pair's product, or a bubble when nothing transferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld[0]   <= 1'b0;
      id_q[0]  <= 1'b0;
      res_q[0] <= '0;
    end else if (adv) begin
      vld[0]   <= xfer;
      id_q[0]  <= grant;
      res_q[0] <= prod;
    end
  end

  for (genvar s = 1; s < STAGES; s++) begin : g_stage
    // Later stages copy their predecessor whenever the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld[s]   <= 1'b0;
        id_q[s]  <= 1'b0;
        res_q[s] <= '0;
      end else if (adv) begin
        vld[s]   <= vld[s-1];
        id_q[s]  <= id_q[s-1];
        res_q[s] <= res_q[s-1];
      end
    end
  end

  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_id    = id_q[STAGES-1];
  assign bus.out_res   = res_q[STAGES-1];
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  mul_share_arbiter_if #(.n(4)) ia ();
  mul_share_arbiter_if #(.n(4)) ib ();

  mul_share_arbiter #(.n(4), .STAGES(2)) u_dut_a (.clk(clk), .rst(rst), .bus(ia));
  mul_share_arbiter #(.n(4), .STAGES(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x;
    int y;
    int p;
    x = int'(a);
    y = int'(b);
    if (s && a[3]) x = x - 16;
    if (s && b[3]) y = y - 16;
    p = x * y;
    return p[7:0];
  endfunction

  task automatic single(input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic [7:0] exp, input string tag);
    if (!id) begin
      ia.req0_valid = 1'b1; ia.req0_a = a; ia.req0_b = b; ia.req0_signed = s;
    end else begin
      ia.req1_valid = 1'b1; ia.req1_a = a; ia.req1_b = b; ia.req1_signed = s;
    end
    #1;
    check({tag, "_ready"}, 32'(id ? ia.req1_ready : ia.req0_ready), 32'd1);
    @(negedge clk);
    ia.req0_valid = 1'b0;
    ia.req1_valid = 1'b0;
    #1;
    check({tag, "_early"}, 32'(ia.out_valid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_out"}, 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'({1'b1, id, exp}));
    @(negedge clk);
  endtask

  logic       expg [6];
  logic [7:0] expr [6];
  logic       g;
  logic [8:0] v;
  logic [3:0] pa, pb;
  logic       ps, pr;

  initial begin
    rst = 1'b1;
    ia.req0_valid = 1'b0; ia.req0_a = '0; ia.req0_b = '0; ia.req0_signed = 1'b0;
    ia.req1_valid = 1'b0; ia.req1_a = '0; ia.req1_b = '0; ia.req1_signed = 1'b0;
    ia.out_ready  = 1'b1;
    ib.req0_valid = 1'b0; ib.req0_a = '0; ib.req0_b = '0; ib.req0_signed = 1'b0;
    ib.req1_valid = 1'b0; ib.req1_a = '0; ib.req1_b = '0; ib.req1_signed = 1'b0;
    ib.out_ready  = 1'b1;
    pa = '0; pb = '0; ps = 1'b0; pr = 1'b0; g = 1'b0;

    #2;
    check("rst_out", 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'd0);
    check("rst_ready", 32'({ia.req0_ready, ia.req1_ready}), 32'b10);
    @(negedge clk);
    rst = 1'b0;

    single(1'b0, 4'hF, 4'h1, 1'b1, 8'hFF, "s_neg1");
    single(1'b0, 4'hF, 4'h1, 1'b0, 8'h0F, "u_15");
    single(1'b0, 4'h8, 4'h8, 1'b1, 8'h40, "s_minmin");
    single(1'b0, 4'hF, 4'hF, 1'b0, 8'hE1, "u_maxmax");
    single(1'b1, 4'h3, 4'h5, 1'b0, 8'h0F, "r1_u");

    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = c[0];
`endif
        expg[c] = g;
        expr[c] = g ? 8'(c * 3) : 8'(c * 2);
        ia.req0_valid = 1'b1; ia.req0_a = 4'(c); ia.req0_b = 4'd2; ia.req0_signed = 1'b0;
        ia.req1_valid = 1'b1; ia.req1_a = 4'(c); ia.req1_b = 4'd3; ia.req1_signed = 1'b0;
        #1;
        check($sformatf("rr_grant_%0d", c), 32'({ia.req0_ready, ia.req1_ready}), 32'({!g, g}));
      end else begin
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b0;
        #1;
      end
      if (c >= 2)
        check($sformatf("rr_out_%0d", c - 2), 32'({ia.out_valid, ia.out_id, ia.out_res}),
              32'({1'b1, expg[c-2], expr[c-2]}));
      @(negedge clk);
    end
    #1;
    check("rr_drained", 32'(ia.out_valid), 32'd0);

    ia.out_ready = 1'b0;
    ia.req0_valid = 1'b1; ia.req0_a = 4'd2; ia.req0_b = 4'd3; ia.req0_signed = 1'b0;
    #1;
    check("stall_fill0", 32'(ia.req0_ready), 32'd1);
    @(negedge clk);
    ia.req0_a = 4'd4; ia.req0_b = 4'd5;
    #1;
    check("stall_fill1", 32'(ia.req0_ready), 32'd1);
    @(negedge clk);
    ia.req0_a = 4'd7; ia.req0_b = 4'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready_%0d", k), 32'({ia.req0_ready, ia.req1_ready}), 32'd0);
      check($sformatf("stall_hold_%0d", k), 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'({1'b1, 1'b0, 8'h06}));
      @(negedge clk);
    end
    ia.out_ready = 1'b1;
    #1;
    check("drain_ready", 32'(ia.req0_ready), 32'd1);
    check("drain_0", 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'({1'b1, 1'b0, 8'h06}));
    @(negedge clk);
    ia.req0_valid = 1'b0;
    #1;
    check("drain_1", 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'({1'b1, 1'b0, 8'h14}));
    @(negedge clk);
    #1;
    check("drain_2", 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'({1'b1, 1'b0, 8'h31}));
    @(negedge clk);
    #1;
    check("drain_empty", 32'(ia.out_valid), 32'd0);

    ia.req0_valid = 1'b1; ia.req0_a = 4'd3; ia.req0_b = 4'd3;
    @(negedge clk);
    ia.req0_a = 4'd5; ia.req0_b = 4'd3;
    @(negedge clk);
    ia.req0_valid = 1'b0;
    #1;
    check("inflight_out", 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'({1'b1, 1'b0, 8'h09}));
    rst = 1'b1;
    #1;
    check("async_rst", 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("no_stale_%0d", k), 32'(ia.out_valid), 32'd0);
    end
    ia.req0_valid = 1'b1; ia.req0_a = 4'd6; ia.req0_b = 4'd2; ia.req0_signed = 1'b0;
    ia.req1_valid = 1'b1; ia.req1_a = 4'd1; ia.req1_b = 4'd1; ia.req1_signed = 1'b0;
    #1;
    check("post_rst_grant", 32'({ia.req0_ready, ia.req1_ready}), 32'b10);
    @(negedge clk);
    ia.req0_valid = 1'b0;
    ia.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_out", 32'({ia.out_valid, ia.out_id, ia.out_res}), 32'({1'b1, 1'b0, 8'h0C}));
    @(negedge clk);

    for (int i = 0; i <= 512; i++) begin
      ib.req0_valid = 1'b0;
      ib.req1_valid = 1'b0;
      v = 9'(i);
      if (i < 512) begin
        if (!v[0]) begin
          ib.req0_valid = 1'b1; ib.req0_a = v[7:4]; ib.req0_b = v[3:0]; ib.req0_signed = v[8];
        end else begin
          ib.req1_valid = 1'b1; ib.req1_a = v[7:4]; ib.req1_b = v[3:0]; ib.req1_signed = v[8];
        end
      end
      #1;
      if (i > 0)
        check($sformatf("sweep_%0d", i - 1), 32'({ib.out_valid, ib.out_id, ib.out_res}),
              32'({1'b1, pr, ref_mul(pa, pb, ps)}));
      pa = v[7:4]; pb = v[3:0]; ps = v[8]; pr = v[0];
      @(negedge clk);
    end
    #1;
    check("sweep_empty", 32'(ib.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
